reg_rst: RTL and testbench

- Parameterised D-type storage register with load enable, per-bit write mask, synchronous clear and asynchronous active-low reset.
- General-purpose state-holding element in misc datapaths: pipeline registers, configuration latches, hold registers.
- Also provides the previous stored value and a one-cycle "changed" strobe so downstream logic can detect updates without extra registers.

---
 rtl/reg_rst_if.sv | 24 ++
 rtl/reg_rst.sv | 78 +++++++
 tb/tb_reg_rst.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_rst_if.sv
// Bundle of the storage register's control, data and status signals.
// The master side drives load/clear/data/mask; the slave (the register)
// drives the stored value, the previous value and the change strobe.
interface reg_rst_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_prev;
  logic             changed;

  modport master (
    output en, clr, d, wmask,
    input  q, q_prev, changed
  );

  modport slave (
    input  en, clr, d, wmask,
    output q, q_prev, changed
  );
endinterface

// File: rtl/reg_rst.sv
// Parameterised D-type storage register with load enable, per-bit write
// mask, synchronous clear and asynchronous active-low reset. Besides the
// stored value it keeps the value held before the last real update and a
// one-cycle strobe marking that update. Every output comes straight from a
// flop.
module reg_rst #(
  parameter int          WIDTH    = 8,
  parameter logic [63:0] RST_VAL  = 64'd0,
  parameter bit          USE_MASK = 1'b1
) (
  input  logic    i_clk,
  input  logic    i_rst,   // asynchronous, active-low
  reg_rst_if.slave bus
);

  // Reset/clear value, truncated to the register width.
  localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

  // Merge new data into the current value under the write mask.
  function automatic logic [WIDTH-1:0] masked_merge(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] data,
    input logic [WIDTH-1:0] mask
  );
    return (data & mask) | (cur & ~mask);
  endfunction

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_prev;
  logic             r_changed;

  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_diff;

  // Next stored value: clear beats load, load beats hold.
  always_comb begin
    w_mask  = {WIDTH{1'b1}};
    w_q_nxt = r_q;
    if (USE_MASK) begin
      w_mask = bus.wmask;
    end else begin
      w_mask = {WIDTH{1'b1}};
    end
    if (bus.clr) begin
      w_q_nxt = RST_Q;
    end else if (bus.en) begin
      w_q_nxt = masked_merge(r_q, bus.d, w_mask);
    end else begin
      // Hold path never looks at d, so an undriven d cannot leak in.
      w_q_nxt = r_q;
    end
    w_diff = (w_q_nxt != r_q);
  end

  // Storage, history and change strobe; history only moves on a real change.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_q       <= RST_Q;
      r_q_prev  <= RST_Q;
      r_changed <= 1'b0;
    end else begin
      r_q <= w_q_nxt;
      if (w_diff) begin
        r_q_prev  <= r_q;
        r_changed <= 1'b1;
      end else begin
        r_q_prev  <= r_q_prev;
        r_changed <= 1'b0;
      end
    end
  end

  assign bus.q       = r_q;
  assign bus.q_prev  = r_q_prev;
  assign bus.changed = r_changed;

endmodule

// File: tb/tb_reg_rst.sv
// Bench for reg_rst: a default 8-bit instance and a 16-bit, RST_VAL=0x1234,
// mask-ignoring instance, both tracked by a behavioural model of the
// register's rules (value, previous value, change strobe).
module tb_reg_rst;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  reg_rst_if #(.WIDTH(8))  u_if8  ();
  reg_rst_if #(.WIDTH(16)) u_if16 ();

  reg_rst #(.WIDTH(8)) u_dut8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if8)
  );

  reg_rst #(.WIDTH(16), .RST_VAL(64'h0000_0000_0000_1234), .USE_MASK(1'b0)) u_dut16 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [7:0]  m8_q,  m8_prev;
  logic        m8_ch;
  logic [15:0] m16_q, m16_prev;
  logic        m16_ch;

  localparam logic [15:0] RV16 = 16'h1234;

  // Behavioural rule: clear wins, then load bit-by-bit where allowed, else hold.
  function automatic logic [15:0] model_next(input int w, input logic [15:0] q,
      input logic [15:0] d, input logic [15:0] m, input logic en, input logic clr,
      input logic use_mask, input logic [15:0] rv);
    logic [15:0] r;
    if (clr) return rv;
    if (!en) return q;
    r = q;
    for (int i = 0; i < w; i++) begin
      if (!use_mask || m[i]) r[i] = d[i];
    end
    return r;
  endfunction

  task automatic model_reset();
    m8_q = 8'h00;  m8_prev = 8'h00;  m8_ch = 1'b0;
    m16_q = RV16;  m16_prev = RV16;  m16_ch = 1'b0;
  endtask

  // Advance one rising edge, update the model from the inputs seen there,
  // then settle just past the edge.
  task automatic tick();
    logic [15:0] n;
    @(posedge clk);
    if (rst) begin
      n = model_next(8, {8'h00, m8_q}, {8'h00, u_if8.d}, {8'h00, u_if8.wmask},
                     u_if8.en, u_if8.clr, 1'b1, 16'h0000);
      m8_ch = (n[7:0] !== m8_q);
      if (m8_ch) m8_prev = m8_q;
      m8_q = n[7:0];
      n = model_next(16, m16_q, u_if16.d, u_if16.wmask,
                     u_if16.en, u_if16.clr, 1'b0, RV16);
      m16_ch = (n !== m16_q);
      if (m16_ch) m16_prev = m16_q;
      m16_q = n;
    end
    #1;
  endtask

  task automatic drive8(input logic en, input logic clr, input logic [7:0] d,
                        input logic [7:0] m);
    u_if8.en = en; u_if8.clr = clr; u_if8.d = d; u_if8.wmask = m;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({u_if8.q, u_if8.q_prev, u_if8.changed} !== {8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset8: got q=%h prev=%h ch=%b expected 00 00 0",
               u_if8.q, u_if8.q_prev, u_if8.changed);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({u_if8.q, u_if8.changed} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: got q=%h ch=%b expected 00 0", u_if8.q, u_if8.changed);
    end
  endtask

  task automatic test_load();
    drive8(1'b1, 1'b0, 8'd31, 8'hFF);
    tick();
    checks++;
    if ({u_if8.q, u_if8.q_prev, u_if8.changed} !== {8'd31, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL load31: got q=%0d prev=%0d ch=%b expected 31 0 1",
               u_if8.q, u_if8.q_prev, u_if8.changed);
    end
    drive8(1'b1, 1'b0, 8'd127, 8'hFF);
    tick();
    checks++;
    if ({u_if8.q, u_if8.q_prev, u_if8.changed} !== {8'd127, 8'd31, 1'b1}) begin
      errors++;
      $display("FAIL load127: got q=%0d prev=%0d ch=%b expected 127 31 1",
               u_if8.q, u_if8.q_prev, u_if8.changed);
    end
  endtask

  task automatic test_hold();
    drive8(1'b0, 1'b0, 8'd12, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({u_if8.q, u_if8.q_prev, u_if8.changed} !== {8'd127, 8'd31, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d]: got q=%0d prev=%0d ch=%b expected 127 31 0",
                 i, u_if8.q, u_if8.q_prev, u_if8.changed);
      end
    end
    u_if8.d = 8'bxxxx_xxxx;
    tick(); tick();
    checks++;
    if ({u_if8.q, u_if8.changed} !== {8'd127, 1'b0}) begin
      errors++;
      $display("FAIL hold_xd: got q=%h ch=%b expected 7f 0", u_if8.q, u_if8.changed);
    end
  endtask

  task automatic test_async_reset();
    drive8(1'b1, 1'b0, 8'd100, 8'hFF);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({u_if8.q, u_if8.q_prev, u_if8.changed} !== {8'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got q=%0d prev=%0d ch=%b expected 0 0 0",
               u_if8.q, u_if8.q_prev, u_if8.changed);
    end
    tick(); tick();
    checks++;
    if (u_if8.q !== 8'd0) begin
      errors++;
      $display("FAIL reset_held: got q=%0d expected 0", u_if8.q);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({u_if8.q, u_if8.q_prev, u_if8.changed} !== {8'd100, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL release_load: got q=%0d prev=%0d ch=%b expected 100 0 1",
               u_if8.q, u_if8.q_prev, u_if8.changed);
    end
  endtask

  task automatic test_clear();
    drive8(1'b1, 1'b1, 8'd55, 8'hFF);
    tick();
    checks++;
    if ({u_if8.q, u_if8.q_prev, u_if8.changed} !== {8'd0, 8'd100, 1'b1}) begin
      errors++;
      $display("FAIL clear1: got q=%0d prev=%0d ch=%b expected 0 100 1",
               u_if8.q, u_if8.q_prev, u_if8.changed);
    end
    tick();
    checks++;
    if ({u_if8.q, u_if8.q_prev, u_if8.changed} !== {8'd0, 8'd100, 1'b0}) begin
      errors++;
      $display("FAIL clear2: got q=%0d prev=%0d ch=%b expected 0 100 0",
               u_if8.q, u_if8.q_prev, u_if8.changed);
    end
  endtask

  task automatic test_mask();
    drive8(1'b1, 1'b0, 8'hF0, 8'hFF);
    tick();
    drive8(1'b1, 1'b0, 8'hAB, 8'h0F);
    tick();
    checks++;
    if ({u_if8.q, u_if8.q_prev, u_if8.changed} !== {8'hFB, 8'hF0, 1'b1}) begin
      errors++;
      $display("FAIL mask_0f: got q=%h prev=%h ch=%b expected fb f0 1",
               u_if8.q, u_if8.q_prev, u_if8.changed);
    end
    drive8(1'b1, 1'b0, 8'h5A, 8'h00);
    tick();
    checks++;
    if ({u_if8.q, u_if8.changed} !== {8'hFB, 1'b0}) begin
      errors++;
      $display("FAIL mask_00: got q=%h ch=%b expected fb 0", u_if8.q, u_if8.changed);
    end
    drive8(1'b1, 1'b0, 8'hFB, 8'hFF);
    tick();
    checks++;
    if ({u_if8.q, u_if8.changed} !== {8'hFB, 1'b0}) begin
      errors++;
      $display("FAIL same_value: got q=%h ch=%b expected fb 0", u_if8.q, u_if8.changed);
    end
  endtask

  task automatic test_param_variant();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({u_if16.q, u_if16.q_prev, u_if16.changed} !== {16'h1234, 16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL w16_reset: got q=%h prev=%h ch=%b expected 1234 1234 0",
               u_if16.q, u_if16.q_prev, u_if16.changed);
    end
    rst = 1'b1;
    u_if16.en = 1'b1; u_if16.clr = 1'b0; u_if16.d = 16'hBEEF; u_if16.wmask = 16'h0000;
    tick();
    checks++;
    if ({u_if16.q, u_if16.q_prev, u_if16.changed} !== {16'hBEEF, 16'h1234, 1'b1}) begin
      errors++;
      $display("FAIL w16_nomask: got q=%h prev=%h ch=%b expected beef 1234 1",
               u_if16.q, u_if16.q_prev, u_if16.changed);
    end
    u_if16.clr = 1'b1;
    tick();
    checks++;
    if ({u_if16.q, u_if16.q_prev, u_if16.changed} !== {16'h1234, 16'hBEEF, 1'b1}) begin
      errors++;
      $display("FAIL w16_clear: got q=%h prev=%h ch=%b expected 1234 beef 1",
               u_if16.q, u_if16.q_prev, u_if16.changed);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive8(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
             8'($urandom), 8'($urandom));
      u_if16.en    = ($urandom_range(0, 2) != 0);
      u_if16.clr   = ($urandom_range(0, 9) == 0);
      u_if16.d     = 16'($urandom_range(0, 3) == 0 ? 16'h1234 : 16'($urandom));
      u_if16.wmask = 16'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      tick();
      checks++;
      if ({u_if8.q, u_if8.q_prev, u_if8.changed} !== {m8_q, m8_prev, m8_ch}) begin
        errors++;
        $display("FAIL rand8[%0d]: got q=%h prev=%h ch=%b expected %h %h %b",
                 i, u_if8.q, u_if8.q_prev, u_if8.changed, m8_q, m8_prev, m8_ch);
      end
      checks++;
      if ({u_if16.q, u_if16.q_prev, u_if16.changed} !== {m16_q, m16_prev, m16_ch}) begin
        errors++;
        $display("FAIL rand16[%0d]: got q=%h prev=%h ch=%b expected %h %h %b",
                 i, u_if16.q, u_if16.q_prev, u_if16.changed, m16_q, m16_prev, m16_ch);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    drive8(1'b0, 1'b0, 8'h00, 8'hFF);
    u_if16.en = 1'b0; u_if16.clr = 1'b0; u_if16.d = 16'h0000; u_if16.wmask = 16'h0000;
    model_reset();
    #2;
    test_reset();
    test_load();
    test_hold();
    test_async_reset();
    test_clear();
    test_mask();
    test_param_variant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
